// File: rtl/week_day_counter.sv
// Day-of-week register feeding the week-day LED decoder.
// Advances on day rollover; two debounced buttons select and step the day in set mode.
module week_day_counter #(
    parameter int unsigned DEBOUNCE_CNT = 3,
    parameter int unsigned RESET_DAY    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_10ms,
    input  logic       tick_500ms,
    input  logic       day_carry,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic [3:0] week_day,
    output logic       set_mode,
    output logic       blank,
    output logic       week_carry
);

    localparam int unsigned DAY_W    = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned NBTN     = 2;
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_UP   = 1;
    localparam logic [DAY_W-1:0] LAST_DAY = DAY_W'(6);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [DAY_W-1:0]   day_q, day_d;
    logic               week_carry_q, week_carry_d;
    logic               set_mode_q, set_mode_d;
    logic               blank_q, blank_d;
    logic               phase_q, phase_d;

    logic [NBTN-1:0]    sync1_q, sync1_d;
    logic [NBTN-1:0]    sync2_q, sync2_d;
    logic [NBTN-1:0]    db_q, db_d;
    logic [NBTN-1:0]    db_prev_q, db_prev_d;
    logic [CNT_W-1:0]   cnt_q [NBTN];
    logic [CNT_W-1:0]   cnt_d [NBTN];

    logic [NBTN-1:0]    press_c;
    logic               mode_press_c;
    logic               up_press_c;

    // Any out-of-range stored value collapses to Sunday on the next step.
    function automatic logic [DAY_W-1:0] next_day(input logic [DAY_W-1:0] d);
        return (d >= LAST_DAY) ? '0 : d + DAY_W'(1);
    endfunction

    assign press_c      = db_q & ~db_prev_q;
    assign mode_press_c = press_c[BTN_MODE];
    assign up_press_c   = press_c[BTN_UP];

    // Synchroniser, tick-sampled debounce and rising-edge detect for both buttons.
    always_comb begin
        sync1_d   = {btn_up, btn_mode};
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        for (int i = 0; i < int'(NBTN); i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_10ms) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == CNT_W'(DEBOUNCE_CNT - 1)) begin
                        db_d[i]  = sync2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // Run/set state machine, day update and blink phase.
    always_comb begin
        state_d      = state_q;
        day_d        = day_q;
        phase_d      = phase_q;
        week_carry_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (day_carry) begin
                    day_d        = next_day(day_q);
                    week_carry_d = (day_q == LAST_DAY);
                end
                if (mode_press_c) begin
                    state_d = ST_SET;
                    phase_d = 1'b0;
                end
            end
            ST_SET: begin
                if (mode_press_c) begin
                    state_d = ST_RUN;
                    phase_d = 1'b0;
                end else if (up_press_c) begin
                    day_d   = next_day(day_q);
                    phase_d = 1'b0;
                end else if (tick_500ms) begin
                    phase_d = ~phase_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                phase_d = 1'b0;
            end
        endcase

        set_mode_d = (state_d == ST_SET);
        blank_d    = set_mode_d & phase_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            day_q        <= DAY_W'(RESET_DAY);
            week_carry_q <= 1'b0;
            set_mode_q   <= 1'b0;
            blank_q      <= 1'b0;
            phase_q      <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            db_prev_q    <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            day_q        <= day_d;
            week_carry_q <= week_carry_d;
            set_mode_q   <= set_mode_d;
            blank_q      <= blank_d;
            phase_q      <= phase_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            db_prev_q    <= db_prev_d;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign week_day   = day_q;
    assign set_mode   = set_mode_q;
    assign blank      = blank_q;
    assign week_carry = week_carry_q;

endmodule
